// File: rtl/teclado_matricial_if.sv
// Keypad-side lines (rows in, columns out) and the accepted-key outputs of the scanner.
// master = scanner, slave = keypad/operand-capture side; no handshake, pulses are fire-and-forget.
interface teclado_matricial_if;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] tecla;
    logic       tecla_valida;
    logic       tecla_presionada;

    modport master (
        input  filas,
        output columnas,
        output tecla,
        output tecla_valida,
        output tecla_presionada
    );

    modport slave (
        output filas,
        input  columnas,
        input  tecla,
        input  tecla_valida,
        input  tecla_presionada
    );
endinterface

// File: rtl/teclado_matricial.sv
// 4x4 keypad scanner/debouncer: one tecla_valida pulse per accepted press, DEBOUNCE_CYCLES+1 after the row sample.
// No backpressure: downstream must take the pulse in the cycle it appears.
module teclado_matricial #(
    parameter int SCAN_DIV        = 27000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic                 clk,
    input  logic                 rst,
    teclado_matricial_if.master  kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        PRESS        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [3:0]       filas_m, filas_s;
    logic [DIV_W-1:0] div, div_n;
    logic [DEB_W-1:0] cnt, cnt_n;
    logic [1:0]       col, col_n;
    logic [1:0]       cand_row, cand_row_n;
    logic [1:0]       low_row;
    logic             any_low;
    logic             row_low;
    logic [3:0]       tecla_q;
    logic             valida_q;
    logic             presionada_q;

    function automatic logic [3:0] codigo(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest-index low row has priority when several keys share the column.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!filas_s[i]) low_row = 2'(i);
        end
    end

    assign any_low = ~&filas_s;
    assign row_low = ~filas_s[cand_row];

    always_comb begin
        state_n    = state;
        div_n      = div;
        cnt_n      = cnt;
        col_n      = col;
        cand_row_n = cand_row;
        case (state)
            SCAN: begin
                if (div == DIV_LAST) begin
                    div_n = '0;
                    if (any_low) begin
                        state_n    = DEBOUNCE;
                        cand_row_n = low_row;
                        cnt_n      = '0;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    div_n = div + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_low) begin
                    state_n = SCAN;
                    col_n   = col + 2'd1;
                    cnt_n   = '0;
                    div_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = PRESS;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESS: begin
                state_n = WAIT_RELEASE;
                cnt_n   = '0;
            end
            WAIT_RELEASE: begin
                // Any low glitch restarts the release count.
                if (row_low) begin
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = SCAN;
                    col_n   = col + 2'd1;
                    cnt_n   = '0;
                    div_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SCAN;
            filas_m      <= 4'hF;
            filas_s      <= 4'hF;
            div          <= '0;
            cnt          <= '0;
            col          <= 2'd0;
            cand_row     <= 2'd0;
            tecla_q      <= 4'h0;
            valida_q     <= 1'b0;
            presionada_q <= 1'b0;
        end else begin
            state        <= state_n;
            filas_m      <= kp.filas;
            filas_s      <= filas_m;
            div          <= div_n;
            cnt          <= cnt_n;
            col          <= col_n;
            cand_row     <= cand_row_n;
            valida_q     <= (state_n == PRESS);
            presionada_q <= (state_n == PRESS) || (state_n == WAIT_RELEASE);
            if (state_n == PRESS) tecla_q <= codigo(cand_row, col);
        end
    end

    assign kp.columnas         = ~(4'b0001 << col);
    assign kp.tecla            = tecla_q;
    assign kp.tecla_valida     = valida_q;
    assign kp.tecla_presionada = presionada_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// Directed bench for teclado_matricial with SCAN_DIV=4, DEBOUNCE_CYCLES=8 and a shorting keypad model.
module tb_teclado_matricial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] keys = 16'h0;   // bit r*4+c = key (r,c) held
    logic [3:0]  filas_drv;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int width_err = 0;
    logic prev_vld = 1'b0;
    logic [3:0] codes[$];

    teclado_matricial_if bus();

    teclado_matricial #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        filas_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            filas_drv[r] = ~|(keys[r*4 +: 4] & ~bus.columnas);
        end
    end
    assign bus.filas = filas_drv;

    always @(negedge clk) begin
        if (bus.tecla_valida) begin
            pulse_cnt = pulse_cnt + 1;
            codes.push_back(bus.tecla);
            if (prev_vld) width_err = width_err + 1;
        end
        prev_vld = bus.tecla_valida;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic press(input int r, input int c, input int hold);
        keys = 16'h0;
        keys[r*4 + c] = 1'b1;
        idle(hold);
        keys = 16'h0;
    endtask

    typedef struct {
        int         row;
        int         col;
        int         hold;
        int         exp_pulses;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int base;
        int n;
        int changes;
        logic [3:0] prev_col;

        vecs[0]  = '{0, 0, 60, 1, 4'h1};
        vecs[1]  = '{2, 2,  4, 0, 4'h1};  // too short to pass debounce
        vecs[2]  = '{0, 1, 60, 1, 4'h2};
        vecs[3]  = '{0, 2, 60, 1, 4'h3};
        vecs[4]  = '{0, 3, 60, 1, 4'hA};
        vecs[5]  = '{1, 0, 60, 1, 4'h4};
        vecs[6]  = '{1, 1, 60, 1, 4'h5};
        vecs[7]  = '{1, 2, 60, 1, 4'h6};
        vecs[8]  = '{1, 3, 60, 1, 4'hB};
        vecs[9]  = '{2, 0, 60, 1, 4'h7};
        vecs[10] = '{2, 1, 60, 1, 4'h8};
        vecs[11] = '{2, 2, 60, 1, 4'h9};
        vecs[12] = '{2, 3, 60, 1, 4'hC};
        vecs[13] = '{3, 0, 60, 1, 4'hE};
        vecs[14] = '{3, 2, 60, 1, 4'hF};
        vecs[15] = '{3, 1, 60, 1, 4'h0};
        vecs[16] = '{3, 3, 60, 1, 4'hD};

        // Reset state
        idle(3);
        check("rst_columnas", int'(bus.columnas), 4'hE);
        check("rst_tecla", int'(bus.tecla), 0);
        check("rst_valida", int'(bus.tecla_valida), 0);
        check("rst_presionada", int'(bus.tecla_presionada), 0);
        rst = 1'b0;
        idle(5);

        // Key map table
        foreach (vecs[i]) begin
            base = pulse_cnt;
            press(vecs[i].row, vecs[i].col, vecs[i].hold);
            idle(30);
            check($sformatf("tbl%0d_pulses", i), pulse_cnt - base, vecs[i].exp_pulses);
            check($sformatf("tbl%0d_tecla", i), int'(bus.tecla), int'(vecs[i].exp_code));
        end

        // Single press (1,1), release timing and scan resume column
        base = pulse_cnt;
        keys = 16'h0;
        keys[1*4 + 1] = 1'b1;
        idle(100);
        check("single_presionada", int'(bus.tecla_presionada), 1);
        keys = 16'h0;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.tecla_presionada && n < 30);
        check_range("single_release_delay", n, 8, 10);
        check("single_resume_col", int'(bus.columnas), 4'hB);
        check("single_pulses", pulse_cnt - base, 1);
        check("single_tecla", int'(bus.tecla), 4'h5);
        idle(20);

        // Press bounce on (3,1): never stable long enough
        base = pulse_cnt;
        for (int k = 0; k < 3; k++) begin
            keys = 16'h0;
            keys[3*4 + 1] = 1'b1;
            idle(5);
            keys = 16'h0;
            idle(2);
        end
        idle(20);
        check("bounce_pulses", pulse_cnt - base, 0);
        check("bounce_tecla", int'(bus.tecla), 4'h5);
        changes = 0;
        prev_col = bus.columnas;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.columnas != prev_col) changes++;
            prev_col = bus.columnas;
        end
        check_range("bounce_rotating", changes, 2, 4);

        // Long hold of (0,3) with 3-cycle release glitches
        base = pulse_cnt;
        keys = 16'h0;
        for (int i = 0; i < 500; i++) begin
            keys[0*4 + 3] = !((i % 60) >= 57);
            step();
        end
        keys = 16'h0;
        idle(30);
        check("hold_pulses", pulse_cnt - base, 1);
        check("hold_tecla", int'(bus.tecla), 4'hA);

        // Operand entry 1,2,3,4
        base = pulse_cnt;
        press(0, 0, 60); idle(60);
        press(0, 1, 60); idle(60);
        press(0, 2, 60); idle(60);
        press(1, 0, 60); idle(60);
        check("entry_pulses", pulse_cnt - base, 4);
        if (pulse_cnt - base == 4) begin
            check("entry_d0", int'(codes[base]), 4'h1);
            check("entry_d1", int'(codes[base + 1]), 4'h2);
            check("entry_d2", int'(codes[base + 2]), 4'h3);
            check("entry_d3", int'(codes[base + 3]), 4'h4);
        end

        // Rows 0 and 2 of column 2 together
        base = pulse_cnt;
        keys = 16'h0;
        keys[0*4 + 2] = 1'b1;
        keys[2*4 + 2] = 1'b1;
        idle(60);
        keys = 16'h0;
        idle(30);
        check("two_rows_pulses", pulse_cnt - base, 1);
        check("two_rows_tecla", int'(bus.tecla), 4'h3);

        // Reset 4 cycles into DEBOUNCE of (2,0): align to the start of the column-0 slot
        prev_col = bus.columnas;
        n = 0;
        step();
        while (!(bus.columnas == 4'hE && prev_col == 4'h7) && n < 40) begin
            prev_col = bus.columnas;
            step();
            n++;
        end
        check("align_found", int'(n < 40), 1);
        base = pulse_cnt;
        keys = 16'h0;
        keys[2*4 + 0] = 1'b1;
        idle(8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_columnas", int'(bus.columnas), 4'hE);
        check("midrst_tecla", int'(bus.tecla), 0);
        check("midrst_presionada", int'(bus.tecla_presionada), 0);
        check("midrst_no_pulse", pulse_cnt - base, 0);
        n = 0;
        while (pulse_cnt == base && n < 80) begin
            step();
            n++;
        end
        check("midrst_pulse_seen", int'(pulse_cnt - base), 1);
        check("midrst_tecla_after", int'(bus.tecla), 4'h7);
        keys = 16'h0;
        idle(30);

        check("pulse_width_errors", width_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/teclado_matricial.md
# teclado_matricial

Scanner and debouncer for the 4x4 matrix keypad. It drives the keypad columns, synchronizes and debounces the row lines, and encodes each accepted keypress as a 4-bit hex code. It sits directly upstream of operand capture. Every accepted press produces exactly one `tecla_valida` pulse with a stable `tecla` value, and capture consumes one hex digit per pulse.

## Interface

Parameters:
- `SCAN_DIV`, default 27000: clock cycles each column stays driven (1 ms at 27 MHz); legal range ≥ 4.
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable cycles required to accept a press or a release (10 ms); legal range ≥ 2.

Ports:
- `clk`  in  1: single system clock.
- `rst`  in  1: reset, synchronous, active-high.
- `filas`  in  4: keypad rows, active-low, asynchronous to `clk`, externally pulled up.
- `columnas`  out  4: column drive, active-low one-hot.
- `tecla`  out  4: hex code of the last accepted key; held until the next accepted key.
- `tecla_valida`  out  1: one-cycle pulse when a new key is accepted.
- `tecla_presionada`  out  1: high from acceptance until the release is debounced.

## Operation

- **Row synchronizer.** `filas` passes through a 2-FF synchronizer to give `filas_s`. All decisions use `filas_s` only.
- **Key map** (row r, col c → code):
  - Row 0: 1, 2, 3, A
  - Row 1: 4, 5, 6, B
  - Row 2: 7, 8, 9, C
  - Row 3: E (`*`), 0, F (`#`), D
- **State machine** (states SCAN, DEBOUNCE, PRESS, WAIT_RELEASE):
  - **SCAN**
    - `columnas` rotates 1110 → 1101 → 1011 → 0111 → 1110, advancing every `SCAN_DIV` cycles.
    - Rows are sampled only in the last cycle of each column slot (divider = `SCAN_DIV`-1), which gives the lines time to settle.
    - If any `filas_s` bit is low at the sample point:
      - latch the candidate row (lowest-index low row wins) and the current column;
      - freeze `columnas`, clear the counter, go to DEBOUNCE.
    - Otherwise advance to the next column.
  - **DEBOUNCE**
    - Column stays frozen.
    - Each cycle that `filas_s[cand_row]` is low, increment the counter.
    - Any high cycle: return to SCAN, advance to the next column, clear the counter and divider.
    - When the counter reaches `DEBOUNCE_CYCLES`-1 on a low cycle: go to PRESS.
  - **PRESS** (exactly 1 cycle)
    - `tecla` ← mapped code; `tecla_valida` = 1.
    - Go to WAIT_RELEASE.
  - **WAIT_RELEASE**
    - Column stays frozen.
    - Counter counts consecutive cycles with `filas_s[cand_row]` high; any low cycle clears it.
    - At `DEBOUNCE_CYCLES` consecutive high cycles: go to SCAN, advance the column, clear the counters.
- **Ignored inputs.** Other keys pressed during DEBOUNCE, PRESS or WAIT_RELEASE are ignored. Other rows are not examined.
- **Output definitions.**
  - `tecla_presionada` = (state == PRESS or WAIT_RELEASE).
  - `tecla_valida` = (state == PRESS), registered.
- **Counter sizing.** Counter widths are `$clog2` of the parameter. Counters never wrap; they are cleared on every state exit.

## Timing

- **Reset values.** While `rst` = 1 at a rising edge, the following take effect at the next edge:
  - state = SCAN
  - `columnas` = 4'b1110
  - `tecla` = 4'h0
  - `tecla_valida` = 0
  - `tecla_presionada` = 0
  - divider, debounce counter and synchronizer are all cleared (synchronizer to 1111)
- **Reset mid-operation.** Reset in any state aborts that state immediately. No `tecla_valida` pulse is produced for a key in progress.
- **Press latency.**
  - `filas` → `filas_s`: 2 cycles.
  - From the sample cycle to `tecla_valida`: exactly `DEBOUNCE_CYCLES`+1 cycles when the row stays low throughout.
- **Pulse width.**
  - `tecla_valida` is high for exactly 1 cycle per press regardless of hold time.
  - `tecla` changes in the same cycle `tecla_valida` rises.
- **No handshake.** There is no backpressure; the downstream stage must accept a pulse in any cycle.
- **Minimum spacing.** Two pulses are separated by at least 2×`DEBOUNCE_CYCLES` cycles.
- **Simultaneous keys in the same column.** The lowest-index row is taken.
- **Keys in different columns.** The first column reached in scan order is taken.
- **Release bounce.** Low glitches during WAIT_RELEASE restart the release count. They do not generate a second pulse.

## Test plan

All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_CYCLES`=8; the keypad model shorts a row to the active column.

- **Single press.** Hold key (1,1) for 100 cycles, then release → exactly one `tecla_valida` pulse with `tecla`=4'h5; `tecla_presionada` drops 8–10 cycles after release; scanning resumes at `columnas`=1011.
- **Press bounce.** Toggle key (3,1) low for 5 cycles, high for 2, repeated 3 times, then release → no pulse; `columnas` keeps rotating; `tecla` stays at its prior value.
- **Long hold and release bounce.** Hold key (0,3) for 500 cycles with 3-cycle release glitches → one pulse with `tecla`=4'hA only.
- **Operand entry.** Press keys 1, 2, 3, 4 in sequence, each held 60 cycles with 60-cycle gaps → four pulses with `tecla` = 1, 2, 3, 4 in order, each pulse exactly 1 cycle wide.
- **Two rows, same column.** Press rows 0 and 2 of column 2 simultaneously → one pulse with `tecla`=4'h3.
- **Reset mid-debounce.** Assert `rst` for 1 cycle, 4 cycles into DEBOUNCE of key (2,0) → no pulse; next edge gives `columnas`=1110, `tecla`=0, `tecla_presionada`=0; continuing to hold the key yields a pulse with `tecla`=4'h7 after a full rescan and debounce.
